// File: rtl/sr_tap_pkg.sv
// sr_tap_pkg: shared constants and types for the tapped shift-register sequencer
package sr_tap_pkg;

    localparam int SR_WIDTH   = 8;
    localparam int SR_DEPTH   = 64;
    localparam int SR_TAP1    = 15;
    localparam int SR_TAP2    = 31;
    localparam int SR_TAP3    = 47;
    localparam int SR_NUM_REQ = 2;

    typedef enum logic {IDLE, FLUSH} sr_seq_state_t;

    typedef logic [SR_WIDTH-1:0] sr_sample_t;

endpackage

// File: rtl/sr_tap_sequencer_rr_arbiter.sv
// rr_arbiter: round-robin grant over NUM_REQ requesters, pointer advances past each accepted winner
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               accept,
    output logic [PW-1:0]      grant_idx
);

    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] grant;

    // Scan from the farthest candidate back toward ptr so the nearest valid requester wins
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                grant                                = '0;
                grant[(int'(ptr) + k) % NUM_REQ]     = 1'b1;
                grant_idx                            = PW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready = en ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    // Pointer moves one past the winner only when a sample is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (accept)
            ptr <= PW'((int'(grant_idx) + 1) % NUM_REQ);
    end

endmodule

// File: rtl/sr_tap_sequencer.sv
// sr_tap_sequencer: arbitrates producers onto a tapped shift register, tracks stage occupancy, flushes on request
// Optional: define SRSEQ_OUT_BACKPRESSURE_EN to add out_ready and stall shifts that would overrun the output
module sr_tap_sequencer
    import sr_tap_pkg::*;
#(
    parameter int WIDTH   = SR_WIDTH,
    parameter int DEPTH   = SR_DEPTH,
    parameter int TAP1    = SR_TAP1,
    parameter int TAP2    = SR_TAP2,
    parameter int TAP3    = SR_TAP3,
    parameter int NUM_REQ = SR_NUM_REQ
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef SRSEQ_OUT_BACKPRESSURE_EN
    input  logic                     out_ready,
`endif
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     flush_req,
    output logic                     flush_busy,
    output logic                     shift,
    output logic [WIDTH-1:0]         sr_in,
    input  logic [WIDTH-1:0]         sr_out,
    output logic [3:0]               tap_valid,
    output logic [6:0]               fill_count,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sr_seq_state_t    state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [DEPTH-1:0] vld;
    logic             in_vld;
    logic             en, accept, stall, eject, shift_nxt;
    logic [WIDTH-1:0] sr_in_nxt;
    logic [PW-1:0]    gidx;

    assign eject      = shift & vld[DEPTH-1];
    assign flush_busy = (state == FLUSH);
    assign tap_valid  = {vld[DEPTH-1], vld[TAP3], vld[TAP2], vld[TAP1]};

`ifdef SRSEQ_OUT_BACKPRESSURE_EN
    // Hold off any shift that would eject while the output slot is occupied or about to be
    assign stall = (shift ? vld[DEPTH-2] : vld[DEPTH-1]) & ((out_valid & ~out_ready) | eject);
`else
    assign stall = 1'b0;
`endif

    assign en = (state == IDLE) & ~flush_req & ~stall;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .accept    (accept),
        .grant_idx (gidx)
    );

    // Next state, flush countdown and the shift command for the following cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = accept;
        sr_in_nxt = accept ? req_data[int'(gidx)*WIDTH +: WIDTH] : '0;
        if (state == IDLE && flush_req) begin
            state_nxt = FLUSH;
            cnt_nxt   = CW'(DEPTH);
        end else if (state == FLUSH && !stall) begin
            shift_nxt = 1'b1;
            cnt_nxt   = cnt - 1'b1;
            state_nxt = (cnt == CW'(1)) ? IDLE : FLUSH;
        end
    end

    // Control state and the registered shift port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shift  <= 1'b0;
            sr_in  <= '0;
            in_vld <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shift  <= shift_nxt;
            sr_in  <= sr_in_nxt;
            in_vld <= accept;
        end
    end

    // Occupancy mirror moves in lockstep with the register; count tracks entries in minus entries out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld        <= '0;
            fill_count <= '0;
        end else if (shift) begin
            vld        <= {vld[DEPTH-2:0], in_vld};
            fill_count <= fill_count + 7'(in_vld) - 7'(vld[DEPTH-1]);
        end
    end

    // Capture the oldest stage as it leaves the register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (eject) begin
            out_valid <= 1'b1;
            out_data  <= sr_out;
`ifdef SRSEQ_OUT_BACKPRESSURE_EN
        end else if (out_ready) begin
            out_valid <= 1'b0;
`else
        end else begin
            out_valid <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_sr_tap_sequencer.sv
// tb_sr_tap_sequencer: randomized and directed checks of sr_tap_sequencer against a queue-based model
module tb_sr_tap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_ready;
    logic        flush_req = 1'b0;
    logic        flush_busy;
    logic        shift;
    logic [7:0]  sr_in;
    logic [7:0]  sr_out;
    logic [3:0]  tap_valid;
    logic [6:0]  fill_count;
    logic        out_valid;
    logic [7:0]  out_data;

    int n_cmp = 0;
    int n_bad = 0;

    sr_tap_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .shift      (shift),
        .sr_in      (sr_in),
        .sr_out     (sr_out),
        .tap_valid  (tap_valid),
        .fill_count (fill_count),
        .out_valid  (out_valid),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    // Stand-in for the 8x64 register datapath
    logic [63:0][7:0] mem;
    always @(posedge clk) if (shift) mem <= {mem[62:0], sr_in};
    assign sr_out = mem[63];

    // Reference model: stage contents as a queue of {valid, data}, index 0 = newest
    logic [8:0]  m_q[$];
    int          m_ptr, m_left;
    logic        m_shift, m_sv, m_ov;
    logic [7:0]  m_sin, m_od;
    int          n_acc[2];
    logic [1:0]  obs_rdy;
    logic [31:0] got, exp;

    task automatic model_reset();
        m_q.delete();
        repeat (64) m_q.push_back(9'h0);
        m_ptr = 0; m_left = 0;
        m_shift = 0; m_sv = 0; m_ov = 0; m_sin = 0; m_od = 0;
        n_acc[0] = 0; n_acc[1] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; req_valid = 0; flush_req = 0;
        #1 model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic step(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1, input logic fl);
        logic [1:0] rdy;
        logic       acc, was;
        logic [8:0] ej;
        int         idx, cnt;
        @(negedge clk);
        req_valid = v; req_data = {d1, d0}; flush_req = fl;
        #1 obs_rdy = req_ready;
        rdy = '0;
        if (m_left == 0 && !fl)
            for (int k = 0; k < 2; k++) begin
                idx = (m_ptr + k) % 2;
                if (rdy == 2'b00 && v[idx]) rdy[idx] = 1'b1;
            end
        acc = |(rdy & v);
        idx = rdy[1] ? 1 : 0;
        was = m_left > 0;
        if (m_shift) begin
            m_q.push_front({m_sv, m_sin});
            ej = m_q.pop_back();
            m_ov = ej[8];
            if (ej[8]) m_od = ej[7:0];
        end else m_ov = 0;
        if (acc) begin
            n_acc[idx]++;
            m_ptr = (idx + 1) % 2;
            m_shift = 1; m_sv = 1; m_sin = idx ? d1 : d0;
        end else if (was) begin
            m_shift = 1; m_sv = 0; m_sin = 0; m_left--;
        end else begin
            m_shift = 0; m_sv = 0; m_sin = 0;
        end
        if (!was && fl) m_left = 64;
        cnt = 0;
        for (int i = 0; i < 64; i++) cnt += int'(m_q[i][8]);
        exp = {rdy, m_shift, m_sin, m_ov, m_od, 7'(cnt), m_q[63][8], m_q[47][8], m_q[31][8], m_q[15][8], m_left > 0};
        @(posedge clk);
        #1 got = {obs_rdy, shift, sr_in, out_valid, out_data, fill_count, tap_valid, flush_busy};
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0; req_valid = 0; flush_req = 0;
        #1 model_reset();
        n_cmp++;
        if ({req_ready, shift, sr_in, flush_busy, out_valid, out_data, fill_count, tap_valid} !== '0) begin
            n_bad++;
            $display("FAIL reset_values got=%h exp=0", {req_ready, shift, sr_in, flush_busy, out_valid, out_data, fill_count, tap_valid});
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 8'h00, 8'h00, 1'b0);
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL reset_idle cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_single();
        int shifts = 0;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(i < 16 ? 2'b01 : 2'b00, 8'(i + 1), 8'($urandom), 1'b0);
            shifts += int'(got[29]);
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL single cyc%0d got=%h exp=%h", i, got, exp); end
        end
        n_cmp++;
        if (shifts != 16) begin n_bad++; $display("FAIL single_shift_count got=%0d exp=16", shifts); end
        n_cmp++;
        if (fill_count !== 7'd16) begin n_bad++; $display("FAIL single_fill got=%0d exp=16", fill_count); end
        n_cmp++;
        if (tap_valid !== 4'b0001) begin n_bad++; $display("FAIL single_taps got=%b exp=0001", tap_valid); end
    endtask

    task automatic test_round_robin();
        logic [7:0] seq[$];
        logic [7:0] want[4];
        want[0] = 8'hA0; want[1] = 8'hB0; want[2] = 8'hA1; want[3] = 8'hB1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(i < 4 ? 2'b11 : 2'b00, 8'(8'hA0 + n_acc[0]), 8'(8'hB0 + n_acc[1]), 1'b0);
            if (shift) seq.push_back(sr_in);
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL rr cyc%0d got=%h exp=%h", i, got, exp); end
            n_cmp++;
            if (obs_rdy === 2'b11) begin n_bad++; $display("FAIL rr_both_ready cyc%0d got=%b exp=onehot", i, obs_rdy); end
        end
        n_cmp++;
        if (seq.size() != 4) begin n_bad++; $display("FAIL rr_seq_len got=%0d exp=4", seq.size()); end
        for (int i = 0; i < 4 && i < seq.size(); i++) begin
            n_cmp++;
            if (seq[i] !== want[i]) begin n_bad++; $display("FAIL rr_seq%0d got=%h exp=%h", i, seq[i], want[i]); end
        end
    endtask

    task automatic test_stream();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 73; i++) begin
            step(i < 70 ? 2'b01 : 2'b00, 8'(i), 8'($urandom), 1'b0);
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL stream cyc%0d got=%h exp=%h", i, got, exp); end
            if (out_valid) begin
                n_cmp++;
                if (out_data !== 8'(pulses)) begin n_bad++; $display("FAIL stream_eject%0d got=%h exp=%h", pulses, out_data, 8'(pulses)); end
                pulses++;
            end
        end
        n_cmp++;
        if (pulses != 6) begin n_bad++; $display("FAIL stream_pulses got=%0d exp=6", pulses); end
        n_cmp++;
        if ({fill_count, tap_valid} !== {7'd64, 4'b1111}) begin n_bad++; $display("FAIL stream_full got=%0d/%b exp=64/1111", fill_count, tap_valid); end
    endtask

    task automatic test_flush();
        int pulses = 0, busy = 0;
        do_reset();
        for (int i = 0; i < 20; i++) step(2'b01, 8'($urandom), 8'($urandom), 1'b0);
        for (int i = 0; i < 67; i++) begin
            step(i < 65 ? 2'b11 : 2'b00, 8'($urandom), 8'($urandom), i == 0);
            pulses += int'(out_valid);
            busy += int'(flush_busy);
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL flush cyc%0d got=%h exp=%h", i, got, exp); end
            if (i >= 1 && i <= 64) begin
                n_cmp++;
                if (obs_rdy !== 2'b00) begin n_bad++; $display("FAIL flush_ready cyc%0d got=%b exp=00", i, obs_rdy); end
            end
        end
        n_cmp++;
        if (busy != 64) begin n_bad++; $display("FAIL flush_busy_len got=%0d exp=64", busy); end
        n_cmp++;
        if (pulses != 20) begin n_bad++; $display("FAIL flush_pulses got=%0d exp=20", pulses); end
        n_cmp++;
        if ({fill_count, tap_valid} !== 11'd0) begin n_bad++; $display("FAIL flush_empty got=%0d/%b exp=0/0000", fill_count, tap_valid); end
    endtask

    task automatic test_flush_collision();
        logic prev_busy = 1'b0;
        int   acc_at = -1;
        do_reset();
        for (int i = 0; i < 70 && acc_at < 0; i++) begin
            step(2'b01, 8'h5A, 8'h00, i == 0);
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL collide cyc%0d got=%h exp=%h", i, got, exp); end
            if (obs_rdy[0]) begin
                acc_at = i;
                n_cmp++;
                if (prev_busy !== 1'b0) begin n_bad++; $display("FAIL collide_early cyc%0d got=busy exp=idle", i); end
            end
            prev_busy = flush_busy;
        end
        n_cmp++;
        if (acc_at != 65) begin n_bad++; $display("FAIL collide_accept_cycle got=%0d exp=65", acc_at); end
    endtask

    task automatic test_reset_midflush();
        do_reset();
        for (int i = 0; i < 10; i++) step(2'b10, 8'($urandom), 8'($urandom), 1'b0);
        for (int i = 0; i < 30; i++) step(2'b00, 8'h00, 8'h00, i == 0);
        n_cmp++;
        if (flush_busy !== 1'b1) begin n_bad++; $display("FAIL midflush_busy got=%b exp=1", flush_busy); end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({shift, flush_busy, tap_valid, fill_count} !== '0) begin
            n_bad++;
            $display("FAIL midflush_async got=%h exp=0", {shift, flush_busy, tap_valid, fill_count});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step(i == 0 ? 2'b01 : 2'b00, 8'h3C, 8'h00, 1'b0);
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL midflush_after cyc%0d got=%h exp=%h", i, got, exp); end
        end
        n_cmp++;
        if (fill_count !== 7'd1) begin n_bad++; $display("FAIL midflush_fresh got=%0d exp=1", fill_count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), $urandom_range(0, 59) == 0);
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL random cyc%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stream();
        test_flush();
        test_flush_collision();
        test_reset_midflush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
